// File: rtl/flag_counter_pkg.sv
// Shared constants and types for the multi-channel flag/tick generator.
package flag_counter_pkg;

  localparam logic MODE_PERIODIC = 1'b0;
  localparam logic MODE_ONESHOT  = 1'b1;

  // Per-channel run state: armed channels count, spent one-shots hold until re-armed.
  typedef enum logic {
    CH_ARMED = 1'b0,
    CH_SPENT = 1'b1
  } ch_state_e;

endpackage

// File: rtl/flag_counter_ch.sv
// One flag/tick channel: enabled-cycle counter with runtime terminal count,
// periodic or one-shot flag generation and sticky one-shot completion.
module flag_counter_ch
  import flag_counter_pkg::*;
#(
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned DEFAULT_TC = 1000
) (
  input  logic             sys_clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             mode,
  input  logic             load,
  input  logic [CNT_W-1:0] load_tc,
  input  logic             clr_done,
  output logic             flag,
  output logic             done,
  output logic             flag_c
);

  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] tc_q, tc_d;
  ch_state_e        state_q, state_d;
  logic             done_d;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      tc_q    <= CNT_W'(DEFAULT_TC);
      state_q <= CH_ARMED;
      flag    <= 1'b0;
      done    <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      state_q <= state_d;
      flag    <= flag_c;
      done    <= done_d;
    end
  end

  // Terminal compares against the current tc, so a load only affects later edges.
  always_comb begin
    count_d = count_q;
    tc_d    = tc_q;
    state_d = state_q;
    done_d  = done;
    flag_c  = 1'b0;

    if (load) tc_d = load_tc;

    if (clr_done) begin
      done_d  = 1'b0;
      state_d = CH_ARMED;
    end

    if (!enable) begin
      count_d = '0;
      state_d = CH_ARMED;
    end else if (state_q == CH_ARMED) begin
      if (count_q >= tc_q) begin
        count_d = '0;
        flag_c  = 1'b1;
        if (mode == MODE_ONESHOT) begin
          done_d  = 1'b1;
          state_d = clr_done ? CH_ARMED : CH_SPENT;
        end
      end else begin
        count_d = count_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/flag_counter_mc.sv
// Multi-channel programmable flag/tick generator: clock input buffer,
// terminal-count load decode, channel array and registered flag OR.
module flag_counter_mc #(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned DEFAULT_TC = 1000,
  parameter int unsigned CH_IDX_W   = 2
) (
  input  logic                clk_p,
  input  logic                clk_n,
  input  logic                rst_n,
  input  logic [NUM_CH-1:0]   enable,
  input  logic [NUM_CH-1:0]   mode,
  input  logic                load,
  input  logic [CH_IDX_W-1:0] load_ch,
  input  logic [CNT_W-1:0]    load_tc,
  input  logic [NUM_CH-1:0]   clr_done,
  output logic [NUM_CH-1:0]   flag_count,
  output logic [NUM_CH-1:0]   done,
  output logic                flag_any
);

  logic              sys_clk;
  logic              unused_clk_n;
  logic [NUM_CH-1:0] ch_load;
  logic [NUM_CH-1:0] flag_next_c;

  // Differential receiver (IBUFGDS, LVDS_25 in the vendor flow); the + leg carries the clock.
  assign sys_clk      = clk_p;
  assign unused_clk_n = clk_n;

  // Indices at or above NUM_CH match no channel and are dropped.
  for (genvar i = 0; i < int'(NUM_CH); i++) begin : g_ch
    assign ch_load[i] = load && (load_ch == CH_IDX_W'(i));

    flag_counter_ch #(
      .CNT_W      (CNT_W),
      .DEFAULT_TC (DEFAULT_TC)
    ) u_ch (
      .sys_clk  (sys_clk),
      .rst_n    (rst_n),
      .enable   (enable[i]),
      .mode     (mode[i]),
      .load     (ch_load[i]),
      .load_tc  (load_tc),
      .clr_done (clr_done[i]),
      .flag     (flag_count[i]),
      .done     (done[i]),
      .flag_c   (flag_next_c[i])
    );
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) flag_any <= 1'b0;
    else        flag_any <= |flag_next_c;
  end

endmodule
